// File: rtl/alu_issue.sv
// Issue front end for an external combinational ALU: request FIFO -> issue register -> response register.
// Define ALU_CHAIN_EN to add req_chain, which feeds the previous result into alu_a instead of req_a.
module alu_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
`ifdef ALU_CHAIN_EN
  input  logic             req_chain,
`endif
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [2:0]       alu_control,
  input  logic [15:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = (AW+1)'(1);

  typedef struct packed {
`ifdef ALU_CHAIN_EN
    logic             chain;
`endif
    logic [2:0]       op;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  entry_t           mem_q [DEPTH];
  entry_t           wr_entry;
  entry_t           issue_q, issue_d;
  logic             issue_valid_q, issue_valid_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      issue_a_eff;

  logic fifo_empty, fifo_full, push, pop, issue_adv;

  // Extra pointer MSB tells a full FIFO (MSBs differ) from an empty one (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push      = req_valid && !fifo_full;
  assign issue_adv = issue_valid_q && (!rsp_valid_q || rsp_ready);
  assign pop       = !fifo_empty && (!issue_valid_q || issue_adv);

`ifdef ALU_CHAIN_EN
  logic [15:0] last_result_q, last_result_d;
  assign issue_a_eff = issue_q.chain ? last_result_q : issue_q.a;
`else
  assign issue_a_eff = issue_q.a;
`endif

  always_comb begin
    wr_entry     = '0;
    wr_entry.op  = req_op;
    wr_entry.a   = req_a;
    wr_entry.b   = req_b;
    wr_entry.tag = req_tag;
`ifdef ALU_CHAIN_EN
    wr_entry.chain = req_chain;
`endif
  end

  // NOTE: every signal gets its hold value first, so no path through the block leaves one unassigned (no latch).
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    issue_d       = issue_q;
    issue_valid_d = issue_valid_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_err_d     = rsp_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_INC;

    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PTR_INC;
      issue_d       = mem_q[rd_ptr_q[AW-1:0]];
      issue_valid_d = 1'b1;
    end else if (issue_adv) begin
      issue_valid_d = 1'b0;
    end

    if (issue_adv) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_out;
      rsp_tag_d   = issue_q.tag;
      rsp_err_d   = (issue_q.op > 3'd2);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

`ifdef ALU_CHAIN_EN
  // Captured alongside the response, so a chained entry entering issue on that same edge sees it.
  assign last_result_d = issue_adv ? alu_out : last_result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_result_q <= '0;
    else     last_result_q <= last_result_d;
  end
`endif

  // NOTE: the storage array is not reset; pointers and valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = !fifo_full;
  assign alu_a       = issue_valid_q ? issue_a_eff : '0;
  assign alu_b       = issue_valid_q ? issue_q.b   : '0;
  assign alu_control = issue_valid_q ? issue_q.op  : 3'b000;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = !fifo_empty || issue_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed steps plus a randomized phase against a queue-based reference model.
// The ALU behind the issue stage is modelled here; define ALU_CHAIN_EN to also exercise operand chaining.
module tb_alu_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, req_valid, req_ready, req_chain;
  logic [2:0]       req_op, alu_control;
  logic [15:0]      req_a, req_b, alu_a, alu_b, alu_out, rsp_data;
  logic [TAG_W-1:0] req_tag, rsp_tag;
  logic             rsp_valid, rsp_ready, rsp_err, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  int rsp_base;
  int n_acc_stall;

  typedef struct {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] prev_result = 16'h0000;
  logic [2:0]  st_op [8];
  logic [15:0] st_a  [8];
  logic [15:0] st_b  [8];

  alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
`ifdef ALU_CHAIN_EN
    .req_chain  (req_chain),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Fixed-point multiply keeps 4 fraction bits: 0x0030 * 0x0020 -> 0x0060.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return p[19:4];
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_control, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference model: every accepted request yields one response, in order; a held response must match the head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      prev_result = 16'h0000;
    end else begin
      if (rsp_valid) begin
        check("rsp_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("mdl_rsp_data", 32'(rsp_data), 32'(e.data));
          check("mdl_rsp_tag",  32'(rsp_tag),  32'(e.tag));
          check("mdl_rsp_err",  32'(rsp_err),  32'(e.err));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            n_rsp++;
          end
        end
      end
      if (req_valid && req_ready) begin
        prev_result = alu_fn(req_op, req_chain ? prev_result : req_a, req_b);
        exp_q.push_back('{prev_result, req_tag, req_op > 3'd2});
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [TAG_W-1:0] tag, input logic chain);
    bit done = 1'b0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag; req_chain = chain;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_chain = 1'b0;
    check("send_accepted", 32'(done), 32'(1));
  endtask

  task automatic expect_rsp(input string name, input logic [15:0] data, input logic [TAG_W-1:0] tag,
                            input logic err);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check({name, "_seen"}, 32'(seen), 32'(1));
    if (seen) begin
      check({name, "_data"}, 32'(rsp_data), 32'(data));
      check({name, "_tag"},  32'(rsp_tag),  32'(tag));
      check({name, "_err"},  32'(rsp_err),  32'(err));
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; req_tag = '0;
    req_chain = 1'b0; rsp_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid",   32'(rsp_valid),   32'(0));
    check("rst_busy",        32'(busy),        32'(0));
    check("rst_alu_a",       32'(alu_a),       32'(0));
    check("rst_alu_b",       32'(alu_b),       32'(0));
    check("rst_alu_control", 32'(alu_control), 32'(0));
    check("rst_rsp_data",    32'(rsp_data),    32'(0));
    check("rst_rsp_tag",     32'(rsp_tag),     32'(0));
    check("rst_rsp_err",     32'(rsp_err),     32'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_req_ready", 32'(req_ready), 32'(1));

    // Minimum latency: accept at N, alu_* after N+1, response after N+2.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h0003; req_b = 16'h0004; req_tag = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("lat_n_rsp_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    check("lat_alu_a",       32'(alu_a),       32'(16'h0003));
    check("lat_alu_b",       32'(alu_b),       32'(16'h0004));
    check("lat_alu_control", 32'(alu_control), 32'(0));
    check("lat_n1_rsp_valid", 32'(rsp_valid),  32'(0));
    @(posedge clk); #1;
    check("lat_rsp_valid", 32'(rsp_valid), 32'(1));
    check("lat_rsp_data",  32'(rsp_data),  32'(16'h0007));
    check("lat_rsp_tag",   32'(rsp_tag),   32'(1));
    check("lat_rsp_err",   32'(rsp_err),   32'(0));

    send(3'd1, 16'h0000, 16'h0001, 4'd4, 1'b0);
    expect_rsp("sub", 16'hFFFF, 4'd4, 1'b0);
    send(3'd2, 16'h0030, 16'h0020, 4'd5, 1'b0);
    expect_rsp("mul", 16'h0060, 4'd5, 1'b0);
    send(3'b101, 16'h1234, 16'h5678, 4'd2, 1'b0);
    expect_rsp("inv", 16'h0000, 4'd2, 1'b1);
    send(3'd0, 16'h0010, 16'h0020, 4'd3, 1'b0);
    expect_rsp("after_inv", 16'h0030, 4'd3, 1'b0);

    // Back-pressure: FIFO plus issue plus response register hold six.
    rsp_ready = 1'b0;
    n_acc_stall = 0;
    for (int i = 0; i < 8; i++) begin
      st_op[i] = 3'($urandom_range(0, 2));
      st_a[i]  = 16'($urandom);
      st_b[i]  = 16'($urandom);
      req_valid = 1'b1; req_op = st_op[i]; req_a = st_a[i]; req_b = st_b[i]; req_tag = 4'(i);
      @(negedge clk);
      if (req_ready) n_acc_stall++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("stall_accepted",  32'(n_acc_stall), 32'(6));
    check("stall_req_ready", 32'(req_ready),   32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("stall_alu_a",       32'(alu_a),       32'(st_a[1]));
    check("stall_alu_b",       32'(alu_b),       32'(st_b[1]));
    check("stall_alu_control", 32'(alu_control), 32'(st_op[1]));
    check("stall_rsp_valid",   32'(rsp_valid),   32'(1));
    check("stall_rsp_data",    32'(rsp_data),    32'(alu_fn(st_op[0], st_a[0], st_b[0])));
    check("stall_rsp_tag",     32'(rsp_tag),     32'(0));
    rsp_base  = n_rsp;
    rsp_ready = 1'b1;
    wait_idle("stall_drain");
    check("stall_rsp_count", 32'(n_rsp - rsp_base), 32'(6));

`ifdef ALU_CHAIN_EN
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h0005; req_b = 16'h0006; req_tag = 4'd6; req_chain = 1'b0;
    @(posedge clk); #1;
    req_a = 16'h0099; req_b = 16'h0001; req_tag = 4'd7; req_chain = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_chain = 1'b0;
    expect_rsp("chain0", 16'h000B, 4'd6, 1'b0);
    expect_rsp("chain1", 16'h000C, 4'd7, 1'b0);
`endif

    // Randomized traffic with random back-pressure; the reference model checks every response.
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      req_tag   = TAG_W'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_CHAIN_EN
      req_chain = 1'($urandom_range(0, 1));
`endif
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_chain = 1'b0; rsp_ready = 1'b1;
    wait_idle("rand_drain");
    check("rand_queue_empty", 32'(exp_q.size()), 32'(0));

    // Reset with three requests in flight: everything is discarded at once.
    rsp_ready = 1'b0;
    send(3'd0, 16'h0001, 16'h0002, 4'd8, 1'b0);
    send(3'd1, 16'h0009, 16'h0003, 4'd9, 1'b0);
    send(3'd2, 16'h0100, 16'h0010, 4'd10, 1'b0);
    check("inflight_busy", 32'(busy), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid",   32'(rsp_valid),   32'(0));
    check("mid_rst_busy",        32'(busy),        32'(0));
    check("mid_rst_req_ready",   32'(req_ready),   32'(1));
    check("mid_rst_alu_control", 32'(alu_control), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_base  = n_rsp;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_rsp", 32'(n_rsp - rsp_base), 32'(0));
    check("post_rst_busy",   32'(busy),             32'(0));
    check("post_rst_queue",  32'(exp_q.size()),     32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
